// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed/unsigned multiplier.
//   mult_state_e : FSM state encoding (idle, iterate, sign-fix)
//   DefaultWidth : default operand width
//   cnt_width()  : bits needed to count 0..w inclusive
package mult_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } mult_state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/comp2_stage.sv
// Conditional two's-complement of an N-bit value.
//   en_i   : 1 = output -data_i, 0 = pass data_i through
//   data_i : N-bit input value
//   data_o : N-bit result
module comp2_stage #(
  parameter int unsigned N = 8
) (
  input  logic         en_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] data_o
);

  assign data_o = en_i ? (~data_i + N'(1)) : data_i;

endmodule

// File: rtl/seq_signed_mult.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Operands are reduced to magnitudes at load, multiplied unsigned over WIDTH cycles,
// then sign-corrected in one final cycle.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : start request, honoured only while o_ready
//   i_a, i_b     : multiplicand / multiplier, captured on accepted start
//   o_ready      : idle, able to accept a start
//   o_done       : one-cycle pulse when o_product/o_sign update
//   o_product    : registered product, held until the next o_done
//   o_sign       : product sign (0 for a zero product or unsigned mode)
module seq_signed_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter bit          SIGNED = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_ready,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_sign
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = cnt_width(WIDTH);

  mult_state_e      state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [PW-1:0]    product_q, product_d;
  logic             sign_q, sign_d;
  logic             done_q, done_d;

  logic             neg_a, neg_b, neg_p;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    acc_fixed;

  assign neg_a = SIGNED & i_a[WIDTH-1];
  assign neg_b = SIGNED & i_b[WIDTH-1];
  assign neg_p = sign_a_q ^ sign_b_q;

  // -2^(WIDTH-1) maps onto itself, which read as unsigned is the correct magnitude.
  comp2_stage #(.N(WIDTH)) u_mag_a (
    .en_i   (neg_a),
    .data_i (i_a),
    .data_o (mag_a)
  );

  comp2_stage #(.N(WIDTH)) u_mag_b (
    .en_i   (neg_b),
    .data_i (i_b),
    .data_o (mag_b)
  );

  comp2_stage #(.N(PW)) u_fix (
    .en_i   (neg_p),
    .data_i (acc_q),
    .data_o (acc_fixed)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    product_d = product_q;
    sign_d    = sign_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          sign_a_d = neg_a;
          sign_b_d = neg_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        product_d = acc_fixed;
        sign_d    = neg_p & (acc_q != '0);
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      product_q <= '0;
      sign_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      product_q <= product_d;
      sign_q    <= sign_d;
      done_q    <= done_d;
    end
  end

  assign o_ready   = (state_q == StIdle);
  assign o_done    = done_q;
  assign o_product = product_q;
  assign o_sign    = sign_q;

endmodule

// File: tb/tb_seq_signed_mult.sv
// Bench for seq_signed_mult: a signed and an unsigned instance share stimulus and are
// checked every cycle against an arithmetic model, plus literal expectations.
module tb_seq_signed_mult;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 16;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;

  logic          rdy_s, done_s, sgn_s;
  logic          rdy_u, done_u, sgn_u;
  logic [PW-1:0] prod_s, prod_u;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: cycles remaining until the result appears; 0 means idle.
  int            m_cnt     = 0;
  bit            m_done    = 1'b0;
  logic [PW-1:0] m_prod_s  = '0;
  logic [PW-1:0] m_prod_u  = '0;
  bit            m_sign_s  = 1'b0;
  logic [PW-1:0] pend_s    = '0;
  logic [PW-1:0] pend_u    = '0;
  bit            pend_sign = 1'b0;

  always #5 clk = ~clk;

  seq_signed_mult #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_a       (a),
    .i_b       (b),
    .o_ready   (rdy_s),
    .o_done    (done_s),
    .o_product (prod_s),
    .o_sign    (sgn_s)
  );

  seq_signed_mult #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_a       (a),
    .i_b       (b),
    .o_ready   (rdy_u),
    .o_done    (done_u),
    .o_product (prod_u),
    .o_sign    (sgn_u)
  );

  function automatic int sval(input logic [W-1:0] x);
    int r;
    r = int'(x);
    if (x[W-1]) r = r - (1 << W);
    return r;
  endfunction

  function automatic logic [PW-1:0] smul(input logic [W-1:0] x, input logic [W-1:0] y);
    return PW'(sval(x) * sval(y));
  endfunction

  function automatic logic [PW-1:0] umul(input logic [W-1:0] x, input logic [W-1:0] y);
    int xu, yu;
    xu = int'(x);
    yu = int'(y);
    return PW'(xu * yu);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'h00;
      3:       return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_cnt    <= 0;
      m_done   <= 1'b0;
      m_prod_s <= '0;
      m_prod_u <= '0;
      m_sign_s <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt     <= W + 1;
          pend_s    <= smul(a, b);
          pend_u    <= umul(a, b);
          pend_sign <= (sval(a) * sval(b)) < 0;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done   <= 1'b1;
          m_prod_s <= pend_s;
          m_prod_u <= pend_u;
          m_sign_s <= pend_sign;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_s", rdy_s, m_cnt == 0);
      check("done_s", done_s, m_done);
      check("prod_s", prod_s, m_prod_s);
      check("sign_s", sgn_s, m_sign_s);
      check("ready_u", rdy_u, m_cnt == 0);
      check("done_u", done_u, m_done);
      check("prod_u", prod_u, m_prod_u);
      check("sign_u", sgn_u, 1'b0);
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [PW-1:0] es, input logic ess, input logic [PW-1:0] eu);
    int j;
    @(negedge clk);
    j = 0;
    while (!rdy_s && j < 40) begin
      @(negedge clk);
      j++;
    end
    start = 1'b1;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    j     = 0;
    while (!done_s && j < 40) begin
      @(negedge clk);
      j++;
    end
    check("latency", PW'(j), PW'(W + 1));
    check("lit_prod_s", prod_s, es);
    check("lit_sign_s", sgn_s, ess);
    check("lit_prod_u", prod_u, eu);
  endtask

  initial begin
    int j;
    int ndone;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", rdy_s, 1'b1);
    check("rst_done", done_s, 1'b0);
    check("rst_prod", prod_s, 16'h0000);
    rst = 1'b0;

    run_op(8'd7,   8'hFD, 16'hFFEB, 1'b1, 16'h06EB);
    run_op(8'h80,  8'h80, 16'h4000, 1'b0, 16'h4000);
    run_op(8'h80,  8'h7F, 16'hC080, 1'b1, 16'h3F80);
    run_op(8'hFB,  8'h00, 16'h0000, 1'b0, 16'h0000);
    run_op(8'hFF,  8'hFF, 16'h0001, 1'b0, 16'hFE01);

    // Start held high: busy-time starts ignored, second op taken in the done cycle.
    @(negedge clk);
    start = 1'b1;
    a     = 8'd3;
    b     = 8'd4;
    @(negedge clk);
    a = 8'd6;
    b = 8'hFE;
    j = 0;
    while (!done_s && j < 40) begin
      @(negedge clk);
      j++;
    end
    check("hs_prod1_s", prod_s, 16'd12);
    check("hs_prod1_u", prod_u, 16'd12);
    j = 0;
    @(negedge clk);
    j++;
    while (!done_s && j < 40) begin
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    check("hs_spacing", PW'(j), PW'(W + 2));
    check("hs_prod2_s", prod_s, 16'hFFF4);
    check("hs_sign2_s", sgn_s, 1'b1);
    check("hs_prod2_u", prod_u, 16'h05F4);

    // Abort 9*9 mid-calculation.
    @(negedge clk);
    start = 1'b1;
    a     = 8'd9;
    b     = 8'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", rdy_s, 1'b1);
    check("abort_prod", prod_s, 16'h0000);
    check("abort_done", done_s, 1'b0);
    rst   = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_s || done_u) ndone++;
    end
    check("abort_no_done", PW'(ndone), 16'd0);
    run_op(8'd2, 8'd3, 16'd6, 1'b0, 16'd6);

    // Random traffic with corner-biased operands and occasional resets.
    repeat (600) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      a     = pick();
      b     = pick();
      rst   = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (14) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
